// File: rtl/bus_memory.sv
// Unibus slave memory: answers DATI/DATIP/DATO/DATOB cycles in an ARM-programmed window.
// Optional hit counters on ARM register 5 when BUS_MEMORY_STATS_EN is defined.
module bus_memory #(
    parameter int unsigned ADDR_BITS = 12,
    parameter int unsigned DESKEW    = 8
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        armwrite,
    input  logic [2:0]  armraddr,
    input  logic [2:0]  armwaddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    input  logic [17:0] a_in_h,
    input  logic [1:0]  c_in_h,
    input  logic [15:0] d_in_h,
    input  logic        init_in_h,
    input  logic        msyn_in_h,
    output logic [15:0] d_out_h,
    output logic        ssyn_out_h
);
    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam int unsigned CW    = $clog2(DESKEW + 1);
    localparam logic [16:0] SIZE_MAX = 17'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_MISSWAIT, S_ACCESS, S_RDATA, S_SSYN} state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt;
    logic                   enable, busy, arm_op_wr, arm_rd_pend;
    logic [16:0]            base, size, diff;
    logic [ADDR_BITS-1:0]   armaddr, lat_idx, ram_raddr, ram_waddr;
    logic [15:0]            armdata, lat_d, ram_q, ram_wdata, d_nxt;
    logic [1:0]             lat_c;
    logic                   lat_lane, hit, latch, ssyn_nxt;
    logic                   arm_go, arm_rd_go, arm_wr_go, we_lo, we_hi, bus_access;
    logic [15:0]            mem [DEPTH];

    assign diff       = a_in_h[17:1] - base;
    assign hit        = enable && (diff < size);
    assign latch      = (state == S_IDLE) && msyn_in_h && (cnt == CW'(DESKEW));
    assign arm_go     = (state == S_IDLE) && !msyn_in_h && busy && !arm_rd_pend;
    assign arm_rd_go  = arm_go && !arm_op_wr;
    assign arm_wr_go  = arm_go && arm_op_wr;
    assign bus_access = (state == S_ACCESS) && !init_in_h;

    // RAM port steering: bus owns the port outside IDLE, ARM only in quiet IDLE
    always_comb begin
        ram_raddr = arm_rd_go ? armaddr : lat_idx;
        ram_waddr = lat_idx;
        ram_wdata = lat_d;
        we_lo     = 1'b0;
        we_hi     = 1'b0;
        if (bus_access && lat_c[1]) begin
            we_lo = !lat_c[0] || !lat_lane;
            we_hi = !lat_c[0] || lat_lane;
        end else if (arm_wr_go) begin
            ram_waddr = armaddr;
            ram_wdata = armdata;
            we_lo     = 1'b1;
            we_hi     = 1'b1;
        end
    end

    always_ff @(posedge CLOCK) begin
        ram_q <= mem[ram_raddr];
        if (we_lo) mem[ram_waddr][7:0]  <= ram_wdata[7:0];
        if (we_hi) mem[ram_waddr][15:8] <= ram_wdata[15:8];
    end

    // State register, registered bus outputs and deskew/latch datapath
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state      <= S_IDLE;
            ssyn_out_h <= 1'b0;
            d_out_h    <= '0;
            cnt        <= '0;
            lat_idx    <= '0;
            lat_c      <= '0;
            lat_d      <= '0;
            lat_lane   <= 1'b0;
        end else begin
            state      <= state_nxt;
            ssyn_out_h <= ssyn_nxt;
            d_out_h    <= d_nxt;
            if (init_in_h || state != S_IDLE || !msyn_in_h || latch) cnt <= '0;
            else                                                        cnt <= cnt + CW'(1);
            if (latch) begin
                lat_idx  <= diff[ADDR_BITS-1:0];
                lat_c    <= c_in_h;
                lat_d    <= d_in_h;
                lat_lane <= a_in_h[0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (latch) state_nxt = hit ? S_ACCESS : S_MISSWAIT;
            S_MISSWAIT: if (!msyn_in_h) state_nxt = S_IDLE;
            S_ACCESS:   state_nxt = S_RDATA;
            S_RDATA:    state_nxt = S_SSYN;
            S_SSYN:     if (ssyn_out_h && !msyn_in_h) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
        if (init_in_h) state_nxt = S_IDLE;
    end

    always_comb begin
        ssyn_nxt = ssyn_out_h;
        d_nxt    = d_out_h;
        case (state)
            S_RDATA: if (!lat_c[1]) d_nxt = ram_q;
            S_SSYN: begin
                if (!ssyn_out_h) begin
                    ssyn_nxt = 1'b1;
                end else if (!msyn_in_h) begin
                    ssyn_nxt = 1'b0;
                    d_nxt    = '0;
                end
            end
            default: ;
        endcase
        if (init_in_h) begin
            ssyn_nxt = 1'b0;
            d_nxt    = '0;
        end
    end

    // ARM register file and queued RAM access
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            enable      <= 1'b0;
            base        <= '0;
            size        <= '0;
            armaddr     <= '0;
            armdata     <= '0;
            busy        <= 1'b0;
            arm_op_wr   <= 1'b0;
            arm_rd_pend <= 1'b0;
        end else begin
            if (armwrite) begin
                case (armwaddr)
                    3'd1: begin
                        enable <= armwdata[31];
                        base   <= armwdata[16:0];
                    end
                    3'd2: size <= (armwdata > 32'(DEPTH)) ? SIZE_MAX : armwdata[16:0];
                    3'd3: if (!busy) begin
                        armaddr   <= armwdata[ADDR_BITS-1:0];
                        busy      <= 1'b1;
                        arm_op_wr <= 1'b0;
                    end
                    3'd4: if (!busy) begin
                        armdata   <= armwdata[15:0];
                        busy      <= 1'b1;
                        arm_op_wr <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (arm_rd_go) arm_rd_pend <= 1'b1;
            if (arm_rd_pend) begin
                armdata     <= ram_q;
                busy        <= 1'b0;
                arm_rd_pend <= 1'b0;
            end
            if (arm_wr_go) begin
                armaddr <= armaddr + ADDR_BITS'(1);
                busy    <= 1'b0;
            end
        end
    end

`ifdef BUS_MEMORY_STATS_EN
    logic [15:0] stat_rd, stat_wr;

    // Saturating hit counters, cleared by any ARM write to register 5
    always_ff @(posedge CLOCK) begin
        if (RESET || (armwrite && armwaddr == 3'd5)) begin
            stat_rd <= '0;
            stat_wr <= '0;
        end else if (bus_access) begin
            if (!lat_c[1] && stat_rd != 16'hFFFF) stat_rd <= stat_rd + 16'd1;
            if (lat_c[1]  && stat_wr != 16'hFFFF) stat_wr <= stat_wr + 16'd1;
        end
    end
`endif

    always_comb begin
        armrdata = 32'hDEADBEEF;
        case (armraddr)
            3'd0: armrdata = 32'h424D2002;
            3'd1: armrdata = {enable, 14'b0, base};
            3'd2: armrdata = {15'b0, size};
            3'd3: armrdata = {busy, 31'(armaddr)};
            3'd4: armrdata = {16'b0, armdata};
`ifdef BUS_MEMORY_STATS_EN
            3'd5: armrdata = {stat_wr, stat_rd};
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_bus_memory.sv
// Directed self-checking bench for bus_memory: window hits/misses, byte writes, ARM port, INIT abort.
module tb_bus_memory;
    localparam int unsigned DESKEW = 8;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        armwrite = 1'b0;
    logic [2:0]  armraddr = '0;
    logic [2:0]  armwaddr = '0;
    logic [31:0] armwdata = '0;
    logic [31:0] armrdata;
    logic [17:0] a_in_h = '0;
    logic [1:0]  c_in_h = '0;
    logic [15:0] d_in_h = '0;
    logic        init_in_h = 1'b0;
    logic        msyn_in_h = 1'b0;
    logic [15:0] d_out_h;
    logic        ssyn_out_h;

    int vectors = 0;
    int miscompares = 0;

    bus_memory #(.ADDR_BITS(12), .DESKEW(DESKEW)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .armwrite(armwrite), .armraddr(armraddr), .armwaddr(armwaddr),
        .armwdata(armwdata), .armrdata(armrdata),
        .a_in_h(a_in_h), .c_in_h(c_in_h), .d_in_h(d_in_h),
        .init_in_h(init_in_h), .msyn_in_h(msyn_in_h),
        .d_out_h(d_out_h), .ssyn_out_h(ssyn_out_h)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic arm_wr(input logic [2:0] r, input logic [31:0] v);
        @(negedge CLOCK);
        armwrite = 1'b1; armwaddr = r; armwdata = v;
        @(negedge CLOCK);
        armwrite = 1'b0;
    endtask

    task automatic arm_chk(input string tag, input logic [2:0] r, input logic [31:0] exp);
        armraddr = r;
        #1;
        chk(tag, armrdata, exp);
    endtask

    task automatic wait_idle(input string tag);
        logic b;
        b = 1'b1;
        armraddr = 3'd3;
        for (int i = 0; i < 20 && b; i++) begin
            @(negedge CLOCK);
            #1;
            b = armrdata[31];
        end
        chk(tag, 32'(b), 32'd0);
    endtask

    task automatic bus_cycle(input string tag, input logic [17:0] a, input logic [1:0] c,
                             input logic [15:0] d, input logic [15:0] exp);
        @(negedge CLOCK);
        a_in_h = a; c_in_h = c; d_in_h = d; msyn_in_h = 1'b1;
        repeat (DESKEW + 3) @(negedge CLOCK);
        chk({tag, "_ssyn_early"}, 32'(ssyn_out_h), 32'd0);
        @(negedge CLOCK);
        chk({tag, "_ssyn"}, 32'(ssyn_out_h), 32'd1);
        chk({tag, "_data"}, 32'(d_out_h), 32'(exp));
        msyn_in_h = 1'b0;
        @(negedge CLOCK);
        chk({tag, "_release"}, {15'b0, ssyn_out_h, d_out_h}, 32'd0);
    endtask

    task automatic bus_miss(input string tag, input logic [17:0] a);
        logic seen;
        seen = 1'b0;
        @(negedge CLOCK);
        a_in_h = a; c_in_h = 2'b00; msyn_in_h = 1'b1;
        repeat (DESKEW + 8) begin
            @(negedge CLOCK);
            seen = seen | ssyn_out_h | (|d_out_h);
        end
        msyn_in_h = 1'b0;
        repeat (3) begin
            @(negedge CLOCK);
            seen = seen | ssyn_out_h | (|d_out_h);
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    task automatic arm_load(input logic [11:0] addr, input logic [15:0] v);
        arm_wr(3'd3, 32'(addr));
        wait_idle("load_addr_busy");
        arm_wr(3'd4, 32'(v));
        wait_idle("load_data_busy");
    endtask

    task automatic arm_read(input string tag, input logic [11:0] addr, input logic [15:0] exp);
        arm_wr(3'd3, 32'(addr));
        wait_idle({tag, "_busy"});
        arm_chk(tag, 3'd4, 32'(exp));
    endtask

    initial begin
        repeat (3) @(negedge CLOCK);
        RESET = 1'b0;
        @(negedge CLOCK);
        arm_chk("id", 3'd0, 32'h424D2002);
        arm_chk("reset_win", 3'd1, 32'h0);
        arm_chk("reset_arm", 3'd3, 32'h0);
        arm_chk("reg6", 3'd6, 32'hDEADBEEF);
        chk("reset_bus", {15'b0, ssyn_out_h, d_out_h}, 32'd0);
`ifndef BUS_MEMORY_STATS_EN
        arm_chk("reg5_absent", 3'd5, 32'hDEADBEEF);
`endif

        // window setup, including size clamp
        arm_wr(3'd1, 32'h8000_4000);
        arm_chk("base", 3'd1, 32'h8000_4000);
        arm_wr(3'd2, 32'd5000);
        arm_chk("size_clamp", 3'd2, 32'd4096);
        arm_wr(3'd2, 32'd16);
        arm_chk("size", 3'd2, 32'd16);

        // test 1: ARM load then DATI
        arm_load(12'd0, 16'o123456);
        arm_chk("armaddr_inc", 3'd3, 32'd1);
        bus_cycle("dati", 18'o100000, 2'b00, 16'h0, 16'o123456);

        // test 2: byte writes, then full-word DATO read back via DATIP
        arm_load(12'd0, 16'h0000);
        bus_cycle("datob_hi", 18'o100001, 2'b11, 16'o177777, 16'h0);
        arm_read("rb_hi", 12'd0, 16'o177400);
        bus_cycle("datob_lo", 18'o100000, 2'b11, 16'o177777, 16'h0);
        arm_read("rb_lo", 12'd0, 16'o177777);
        bus_cycle("dato", 18'o100002, 2'b10, 16'h1234, 16'h0);
        bus_cycle("datip", 18'o100002, 2'b01, 16'h0, 16'h1234);

        // test 3: misses below base and at base+size
        bus_miss("miss_below", 18'o077776);
        bus_miss("miss_top", 18'o100040);

        // test 4: ARM write queued while bus holds SSYN
        arm_wr(3'd3, 32'd5);
        wait_idle("t4_setup_busy");
        @(negedge CLOCK);
        a_in_h = 18'o100000; c_in_h = 2'b00; msyn_in_h = 1'b1;
        repeat (DESKEW + 4) @(negedge CLOCK);
        chk("t4_ssyn", 32'(ssyn_out_h), 32'd1);
        arm_wr(3'd4, 32'h0000BEEF);
        repeat (2) @(negedge CLOCK);
        arm_chk("t4_busy_held", 3'd3, 32'h8000_0005);
        msyn_in_h = 1'b0;
        repeat (2) @(negedge CLOCK);
        arm_chk("t4_landed", 3'd3, 32'd6);
        bus_cycle("t4_read", 18'o100012, 2'b00, 16'h0, 16'hBEEF);

        // test 5: INIT during SSYN, and a DATO cut during deskew
        @(negedge CLOCK);
        a_in_h = 18'o100000; c_in_h = 2'b00; msyn_in_h = 1'b1;
        repeat (DESKEW + 4) @(negedge CLOCK);
        chk("t5_ssyn", {15'b0, ssyn_out_h, d_out_h}, {15'b0, 1'b1, 16'o177777});
        init_in_h = 1'b1;
        @(negedge CLOCK);
        chk("t5_init", {15'b0, ssyn_out_h, d_out_h}, 32'd0);
        init_in_h = 1'b0; msyn_in_h = 1'b0;
        @(negedge CLOCK);
        a_in_h = 18'o100002; c_in_h = 2'b10; d_in_h = 16'hAAAA; msyn_in_h = 1'b1;
        repeat (DESKEW - 2) @(negedge CLOCK);
        init_in_h = 1'b1; msyn_in_h = 1'b0;
        @(negedge CLOCK);
        init_in_h = 1'b0;
        arm_read("t5_unchanged", 12'd1, 16'h1234);

`ifdef BUS_MEMORY_STATS_EN
        // test 6: hit counters
        arm_wr(3'd5, 32'd0);
        bus_cycle("s_rd0", 18'o100000, 2'b00, 16'h0, 16'o177777);
        bus_cycle("s_rd1", 18'o100002, 2'b00, 16'h0, 16'h1234);
        bus_cycle("s_rd2", 18'o100012, 2'b01, 16'h0, 16'hBEEF);
        bus_cycle("s_wr0", 18'o100004, 2'b10, 16'h1111, 16'h0);
        bus_cycle("s_wr1", 18'o100006, 2'b10, 16'h2222, 16'h0);
        bus_miss("s_miss", 18'o100040);
        arm_chk("stats", 3'd5, 32'h0002_0003);
        arm_wr(3'd5, 32'd0);
        arm_chk("stats_clr", 3'd5, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
